// File: rtl/riscv_ex_unit.sv
// Execute-stage slice of the 5-stage RV32I pipeline: load-use hazard detection, operand
// forwarding, the integer ALU with branch evaluation, and the EX/MEM result register.
module riscv_ex_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [XLEN-1:0] EX_dataA,
  input  logic [XLEN-1:0] EX_dataB,
  input  logic [XLEN-1:0] EX_immGenOut,
  input  logic [XLEN-1:0] dataD,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [10:0]     EX_signals,
  input  logic [3:0]      EX_func3_7,
  input  logic [4:0]      EX_Rd,
  input  logic [4:0]      ID_Rs1,
  input  logic [4:0]      ID_Rs2,
  output logic            notStall,
  output logic [XLEN-1:0] aluA,
  output logic [XLEN-1:0] aluB,
  output logic [XLEN-1:0] forwardB_dataB,
  output logic [XLEN-1:0] aluResult,
  output logic            branchFromAlu,
  output logic [XLEN-1:0] MEM_aluResult,
  output logic            MEM_branchFromAlu,
  output logic [XLEN-1:0] MEM_dataB
);

  localparam logic [2:0] AluOpBranch = 3'b001;
  localparam logic [2:0] AluOpRType  = 3'b010;
  localparam logic [2:0] AluOpIType  = 3'b011;
  localparam logic [2:0] AluOpLui    = 3'b100;

  logic [2:0]      alu_op;
  logic            alu_src;
  logic            mem_read;
  logic [2:0]      funct3;
  logic            alt;
  logic [4:0]      shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] int_result;
  logic            unused_ctrl;

  assign alu_op      = EX_signals[10:8];
  assign alu_src     = EX_signals[2];
  assign mem_read    = EX_signals[5];
  assign funct3      = EX_func3_7[2:0];
  // Branch gating (bit 7) and the remaining control bits belong to later stages.
  assign unused_ctrl = ^{EX_signals[7:6], EX_signals[4:3], EX_signals[1:0]};

  assign notStall = !(mem_read && (EX_Rd != 5'd0) && ((EX_Rd == ID_Rs1) || (EX_Rd == ID_Rs2)));

  always_comb begin
    case (forwardA)
      2'b10:   aluA = MEM_aluResult;
      2'b01:   aluA = dataD;
      default: aluA = EX_dataA;
    endcase
    case (forwardB)
      2'b10:   forwardB_dataB = MEM_aluResult;
      2'b01:   forwardB_dataB = dataD;
      default: forwardB_dataB = EX_dataB;
    endcase
  end

  assign aluB = alu_src ? EX_immGenOut : forwardB_dataB;

  assign sum   = aluA + aluB;
  assign diff  = aluA - aluB;
  assign lt_s  = $signed(aluA) < $signed(aluB);
  assign lt_u  = aluA < aluB;
  assign shamt = aluB[4:0];

  // instr[30] only selects sub (R-type) and sra/srai; elsewhere it is ignored.
  assign alt = EX_func3_7[3] &&
               ((funct3 == 3'b101) || ((funct3 == 3'b000) && (alu_op == AluOpRType)));

  always_comb begin
    int_result = sum;
    case (funct3)
      3'b000:  int_result = alt ? diff : sum;
      3'b001:  int_result = aluA << shamt;
      3'b010:  int_result = {{(XLEN-1){1'b0}}, lt_s};
      3'b011:  int_result = {{(XLEN-1){1'b0}}, lt_u};
      3'b100:  int_result = aluA ^ aluB;
      3'b101:  int_result = alt ? $unsigned($signed(aluA) >>> shamt) : (aluA >> shamt);
      3'b110:  int_result = aluA | aluB;
      default: int_result = aluA & aluB;
    endcase
  end

  always_comb begin
    aluResult     = sum;
    branchFromAlu = 1'b0;
    case (alu_op)
      AluOpBranch: begin
        aluResult = diff;
        case (funct3)
          3'b000:  branchFromAlu = (aluA == aluB);
          3'b001:  branchFromAlu = (aluA != aluB);
          3'b100:  branchFromAlu = lt_s;
          3'b101:  branchFromAlu = !lt_s;
          3'b110:  branchFromAlu = lt_u;
          3'b111:  branchFromAlu = !lt_u;
          default: branchFromAlu = 1'b0;
        endcase
      end
      AluOpRType, AluOpIType: aluResult = int_result;
      AluOpLui:               aluResult = aluB;
      default:                aluResult = sum;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      MEM_aluResult     <= '0;
      MEM_branchFromAlu <= 1'b0;
      MEM_dataB         <= '0;
    end else begin
      MEM_aluResult     <= aluResult;
      MEM_branchFromAlu <= branchFromAlu;
      MEM_dataB         <= forwardB_dataB;
    end
  end

endmodule

// File: tb/tb_riscv_ex_unit.sv
// Directed bench for riscv_ex_unit; expectations are queued at drive time and popped on check.
module tb_riscv_ex_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] EX_dataA, EX_dataB, EX_immGenOut, dataD;
  logic [1:0]  forwardA, forwardB;
  logic [10:0] EX_signals;
  logic [3:0]  EX_func3_7;
  logic [4:0]  EX_Rd, ID_Rs1, ID_Rs2;
  logic        notStall;
  logic [31:0] aluA, aluB, forwardB_dataB, aluResult;
  logic        branchFromAlu;
  logic [31:0] MEM_aluResult;
  logic        MEM_branchFromAlu;
  logic [31:0] MEM_dataB;

  int vectors = 0;
  int miscompares = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

  riscv_ex_unit #(.XLEN(32)) dut (
    .clock(clock), .clear(clear), .EX_dataA(EX_dataA), .EX_dataB(EX_dataB),
    .EX_immGenOut(EX_immGenOut), .dataD(dataD), .forwardA(forwardA), .forwardB(forwardB),
    .EX_signals(EX_signals), .EX_func3_7(EX_func3_7), .EX_Rd(EX_Rd), .ID_Rs1(ID_Rs1),
    .ID_Rs2(ID_Rs2), .notStall(notStall), .aluA(aluA), .aluB(aluB),
    .forwardB_dataB(forwardB_dataB), .aluResult(aluResult), .branchFromAlu(branchFromAlu),
    .MEM_aluResult(MEM_aluResult), .MEM_branchFromAlu(MEM_branchFromAlu), .MEM_dataB(MEM_dataB)
  );

  always #5 clock = ~clock;

  function automatic logic [10:0] sig(input logic [2:0] op, input logic br, input logic mr,
                                      input logic src);
    logic [10:0] s;
    s = '0;
    s[10:8] = op;
    s[7] = br;
    s[5] = mr;
    s[2] = src;
    return s;
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (val_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underflow: got %h with nothing expected", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b0;
    EX_dataA = 32'h1234; EX_dataB = 32'h55; EX_immGenOut = 32'h0; dataD = 32'h0;
    forwardA = 2'b00; forwardB = 2'b00;
    EX_signals = sig(3'b000, 1'b0, 1'b0, 1'b0); EX_func3_7 = 4'b0000;
    EX_Rd = 5'd0; ID_Rs1 = 5'd0; ID_Rs2 = 5'd0;

    // Reset flushes the EX/MEM register even though the ALU output is nonzero.
    tick();
    expect_val("reset_mem_alu", 32'h0);       check(MEM_aluResult);
    expect_val("reset_mem_br", 32'h0);        check({31'b0, MEM_branchFromAlu});
    expect_val("reset_mem_dataB", 32'h0);     check(MEM_dataB);
    expect_val("reset_notstall", 32'h1);      check({31'b0, notStall});
    clear = 1'b1;

    // addi then forwarded use.
    EX_signals = sig(3'b011, 1'b0, 1'b0, 1'b1);
    EX_dataA = 32'h0; EX_immGenOut = 32'h8;
    #1;
    expect_val("addi_result", 32'h8);         check(aluResult);
    expect_val("addi_mem_load", 32'h8);
    tick();
    check(MEM_aluResult);
    forwardA = 2'b10; EX_immGenOut = 32'h31;
    #1;
    expect_val("fwd_mem_aluA", 32'h8);        check(aluA);
    expect_val("fwd_mem_result", 32'h39);     check(aluResult);
    forwardA = 2'b01; dataD = 32'h5;
    #1;
    expect_val("fwd_wb_result", 32'h36);      check(aluResult);
    forwardA = 2'b11;
    #1;
    expect_val("fwd_11_aluA", 32'h0);         check(aluA);
    forwardA = 2'b00;

    // Load-use hazard.
    EX_signals = sig(3'b000, 1'b0, 1'b1, 1'b0);
    EX_Rd = 5'd3; ID_Rs1 = 5'd0; ID_Rs2 = 5'd3;
    #1;
    expect_val("loaduse_rs2", 32'h0);         check({31'b0, notStall});
    ID_Rs1 = 5'd3; ID_Rs2 = 5'd7;
    #1;
    expect_val("loaduse_rs1", 32'h0);         check({31'b0, notStall});
    EX_Rd = 5'd0; ID_Rs1 = 5'd0;
    #1;
    expect_val("loaduse_rd0", 32'h1);         check({31'b0, notStall});
    EX_Rd = 5'd3; ID_Rs1 = 5'd3;
    EX_signals = sig(3'b000, 1'b0, 1'b0, 1'b0);
    #1;
    expect_val("loaduse_nomemread", 32'h1);   check({31'b0, notStall});
    EX_Rd = 5'd0; ID_Rs1 = 5'd0; ID_Rs2 = 5'd0;

    // Branches.
    EX_signals = sig(3'b001, 1'b1, 1'b0, 1'b0); EX_func3_7 = 4'b0101;
    EX_dataA = 32'h31; EX_dataB = 32'h31;
    #1;
    expect_val("bge_equal", 32'h1);           check({31'b0, branchFromAlu});
    expect_val("bge_diff", 32'h0);            check(aluResult);
    EX_dataA = 32'hFFFF_FFFF; EX_dataB = 32'h0;
    #1;
    expect_val("bge_neg", 32'h0);             check({31'b0, branchFromAlu});
    expect_val("bge_neg_diff", 32'hFFFF_FFFF); check(aluResult);
    EX_func3_7 = 4'b0111;
    #1;
    expect_val("bgeu_big", 32'h1);            check({31'b0, branchFromAlu});
    expect_val("mem_br_follow", 32'h1);
    tick();
    check({31'b0, MEM_branchFromAlu});
    EX_func3_7 = 4'b0010;
    #1;
    expect_val("branch_f3_010", 32'h0);       check({31'b0, branchFromAlu});
    EX_signals = sig(3'b000, 1'b1, 1'b0, 1'b0); EX_func3_7 = 4'b0000;
    EX_dataA = 32'h7; EX_dataB = 32'h7;
    #1;
    expect_val("nonbranch_op_br", 32'h0);     check({31'b0, branchFromAlu});

    // R-type shifts, sub, compares.
    EX_signals = sig(3'b010, 1'b0, 1'b0, 1'b0);
    EX_func3_7 = 4'b1101; EX_dataA = 32'h8000_0000; EX_dataB = 32'h4;
    #1;
    expect_val("sra", 32'hF800_0000);         check(aluResult);
    EX_func3_7 = 4'b0101;
    #1;
    expect_val("srl", 32'h0800_0000);         check(aluResult);
    EX_func3_7 = 4'b0001; EX_dataA = 32'h1; EX_dataB = 32'h24;
    #1;
    expect_val("sll_shamt_low5", 32'h10);     check(aluResult);
    EX_func3_7 = 4'b1000; EX_dataA = 32'h0; EX_dataB = 32'h1;
    #1;
    expect_val("sub", 32'hFFFF_FFFF);         check(aluResult);
    EX_func3_7 = 4'b0010; EX_dataA = 32'hFFFF_FFFF;
    #1;
    expect_val("slt", 32'h1);                 check(aluResult);
    EX_func3_7 = 4'b0011;
    #1;
    expect_val("sltu", 32'h0);                check(aluResult);
    EX_func3_7 = 4'b1110; EX_dataA = 32'hF0; EX_dataB = 32'h0F;
    #1;
    expect_val("or_alt_ignored", 32'hFF);     check(aluResult);
    EX_func3_7 = 4'b0100; EX_dataA = 32'hFF00_FF00; EX_dataB = 32'h0FF0_0FF0;
    #1;
    expect_val("xor", 32'hF0F0_F0F0);         check(aluResult);
    EX_func3_7 = 4'b0111;
    #1;
    expect_val("and", 32'h0F00_0F00);         check(aluResult);

    // I-type ignores instr[30] for add; lui passes B.
    EX_signals = sig(3'b011, 1'b0, 1'b0, 1'b1); EX_func3_7 = 4'b1000;
    EX_dataA = 32'h5; EX_immGenOut = 32'h3;
    #1;
    expect_val("addi_alt_ignored", 32'h8);    check(aluResult);
    EX_func3_7 = 4'b1101; EX_dataA = 32'h8000_0000; EX_immGenOut = 32'h1;
    #1;
    expect_val("srai", 32'hC000_0000);        check(aluResult);
    EX_signals = sig(3'b100, 1'b0, 1'b0, 1'b1); EX_immGenOut = 32'hABCD_0000;
    #1;
    expect_val("lui", 32'hABCD_0000);         check(aluResult);
    EX_signals = sig(3'b110, 1'b0, 1'b0, 1'b0); EX_dataA = 32'hFFFF_FFFF; EX_dataB = 32'h2;
    #1;
    expect_val("op110_add_wrap", 32'h1);      check(aluResult);

    // Store path with forwarded store data.
    EX_signals = sig(3'b000, 1'b0, 1'b0, 1'b0); EX_func3_7 = 4'b0000;
    EX_dataA = 32'h31; EX_dataB = 32'h0;
    tick();
    EX_signals = sig(3'b000, 1'b0, 1'b0, 1'b1);
    forwardB = 2'b10; EX_immGenOut = 32'hFFFF_FFFF;
    #1;
    expect_val("store_aluB_imm", 32'hFFFF_FFFF); check(aluB);
    expect_val("store_fwd_dataB", 32'h31);    check(forwardB_dataB);
    expect_val("store_mem_dataB", 32'h31);
    tick();
    check(MEM_dataB);
    expect_val("store_mem_addr", 32'h30);     check(MEM_aluResult);
    forwardB = 2'b01; dataD = 32'h77;
    #1;
    expect_val("fwdB_wb", 32'h77);            check(forwardB_dataB);
    forwardB = 2'b11; EX_dataB = 32'h99;
    #1;
    expect_val("fwdB_11", 32'h99);            check(forwardB_dataB);

    // Mid-stream clear flushes; forwarding afterwards sees zero.
    clear = 1'b0;
    tick();
    expect_val("flush_mem_alu", 32'h0);       check(MEM_aluResult);
    expect_val("flush_mem_dataB", 32'h0);     check(MEM_dataB);
    clear = 1'b1; forwardA = 2'b10;
    #1;
    expect_val("fwd_after_clear", 32'h0);     check(aluA);

    if (val_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", val_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_ex_unit.md
Name: riscv_ex_unit

Overview:
Execute-stage datapath slice of the 5-stage pipelined RV32I core. It holds three pieces:
- Load-use hazard detection, which drives the stall line back to IF/ID.
- Operand forwarding/source muxes, which drive the ALU operands and the store data.
- The integer ALU with branch-condition evaluation.
It also owns the EX/MEM result register that serves as the MEM-stage forwarding source.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
clock  in  1  single clock; all state updates on its rising edge
clear  in  1  reset, synchronous, active-low
EX_dataA  in  32  rs1 value read in ID, now in EX
EX_dataB  in  32  rs2 value read in ID, now in EX
EX_immGenOut  in  32  sign-extended immediate in EX
dataD  in  32  write-back value (WB stage)
forwardA  in  2  source select for operand A
forwardB  in  2  source select for operand B / store data
EX_signals  in  11  control word: [2] AluSrc, [5] MemRead, [7] Branch, [10:8] AluOp
EX_func3_7  in  4  {instr[30], funct3}
EX_Rd  in  5  destination register of the instruction in EX
ID_Rs1  in  5  rs1 of the instruction in ID
ID_Rs2  in  5  rs2 of the instruction in ID
notStall  out  1  0 = stall PC and IF/ID, bubble into ID/EX
aluA  out  32  forwarded operand A
aluB  out  32  final operand B (after immediate select)
forwardB_dataB  out  32  forwarded rs2 (store data)
aluResult  out  32  combinational ALU result
branchFromAlu  out  1  combinational branch condition
MEM_aluResult  out  32  registered aluResult
MEM_branchFromAlu  out  1  registered branchFromAlu
MEM_dataB  out  32  registered forwardB_dataB

Behaviour:
Hazard detection (combinational):
- notStall=0 iff EX_signals[5]=1 AND EX_Rd!=0 AND (EX_Rd==ID_Rs1 OR EX_Rd==ID_Rs2).
- notStall=1 otherwise, including while clear=0.

Forwarding (combinational):
- Operand A: forwardA 00 -> EX_dataA; 10 -> MEM_aluResult (internal register); 01 -> dataD; 11 -> EX_dataA.
- forwardB selects forwardB_dataB with the same encoding, using EX_dataB.
- aluA = forwarded A.
- aluB = EX_signals[2] ? EX_immGenOut : forwardB_dataB.

ALU (combinational), selected by AluOp = EX_signals[10:8]; f = EX_func3_7:
- 000: add.
- 001 branch: compare A vs B by funct3.
  - 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu.
  - branchFromAlu = condition; funct3 010/011 give 0.
  - aluResult = A-B.
- 010 R-type, selected by f:
  - 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor.
  - 0101 srl, 1101 sra, 0110 or, 0111 and.
  - Any other value with f[3]=1 is treated as f[3]=0.
- 011 I-type: as R-type, but f[3] is honoured only when funct3=101 (srai); otherwise addi etc.
- 100: aluResult = B (lui).
- 101-111: add.
- Arithmetic rules:
  - Add/sub wrap modulo 2^32.
  - Shift amount = B[4:0].
  - slt/sltu yield 0/1 zero-extended.
  - sra sign-fills.
- branchFromAlu = 0 for every AluOp except 001.
- EX_signals[7] is not used inside the block; branch gating is done in MEM.

EX/MEM register:
- Rising clock with clear=0: MEM_aluResult=0, MEM_branchFromAlu=0, MEM_dataB=0.
- Otherwise every cycle (no enable): load aluResult, branchFromAlu, forwardB_dataB.
- Reset is not asynchronous: outputs keep their value until the first rising edge with clear=0.
- Clear asserted mid-stream flushes the register on that edge.
- A value forwarded with forwardA=10 the cycle after a clear is 0.

Latency:
- notStall, aluA, aluB, forwardB_dataB, aluResult and branchFromAlu settle in 0 cycles.
- MEM_* outputs follow after 1 cycle.

Test Plan:
1. Reset: clear=0 for one edge -> MEM_aluResult=0, MEM_branchFromAlu=0, MEM_dataB=0; with clear=1 they load on the next edge.
2. Forwarding/addi:
   - Cycle 1: AluOp=011, AluSrc=1, f=0000, EX_dataA=0, imm=8 -> aluResult=8.
   - Cycle 2: forwardA=10, imm=0x31 -> aluA=8, aluResult=0x39.
   - Cycle 2 with forwardA=01 instead, dataD=5 -> aluResult=0x36.
3. Load-use: EX_signals[5]=1, EX_Rd=3, ID_Rs2=3 -> notStall=0. With EX_Rd=0 or MemRead=0 -> notStall=1.
4. Branch bge (AluOp=001, f=0101):
   - A=0x31, B=0x31 -> branchFromAlu=1.
   - A=-1, B=0 -> 0.
   - bgeu with A=0xFFFFFFFF, B=0 -> 1.
   - Next edge: MEM_branchFromAlu equals the prior value.
5. Shifts/sub (AluOp=010):
   - f=1101, A=0x80000000, B=4 -> 0xF8000000.
   - f=0101 -> 0x08000000.
   - f=1000, A=0, B=1 -> 0xFFFFFFFF.
   - f=0010, A=-1, B=1 -> 1.
   - f=0011 -> 0.
6. Store path: AluSrc=1, forwardB=10 with MEM_aluResult=0x31, EX_dataB=0, imm=-1 (0xFFFFFFFF):
   - aluB=0xFFFFFFFF, forwardB_dataB=0x31.
   - MEM_dataB=0x31 after the edge.
